// File: rtl/l2_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter_pkg
//   Shared constants and types for the tile L2 request arbitration path.
//   - LOG_N_MSHR / L2_MAX_OUT : bank MSHR depth, which bounds the outstanding
//     reads any single requester may hold.
//   - L2_REQ_W                : opaque request payload width (addr + metadata).
//   - L2_PORTS                : requesters per tile (RO stages + RW read + RW write).
//   - l2_arb_req_t            : one request as seen by the bank pipeline.
//   - clog2_min1()            : index width helper that never returns 0.
// ---------------------------------------------------------------------------
package l2_port_arbiter_pkg;

    localparam int unsigned LOG_N_MSHR   = 4;
    localparam int unsigned L2_MAX_OUT   = 1 << LOG_N_MSHR;
    localparam int unsigned L2_REQ_W     = 64;
    localparam int unsigned L2_RO_STAGES = 2;
    localparam int unsigned L2_PORTS     = L2_RO_STAGES + 2;

    typedef struct packed {
        logic [L2_REQ_W-1:0] payload;
        logic                is_write;
    } l2_arb_req_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The search starts at the entry right
//   after i_ptr and walks upward with wrap-around; the first requester found
//   wins. Reusable by any tile arbiter that keeps its own pointer register.
//   Ports:
//     i_req   [N]      request vector
//     i_ptr   [LOG_N]  index of the most recently served requester
//     o_grant [N]      one-hot grant (all zero when nothing requests)
//     o_idx   [LOG_N]  binary index of the granted requester
//     o_any            a grant was issued
// ---------------------------------------------------------------------------
module rr_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned LOG_N = clog2_min1(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [LOG_N-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [LOG_N-1:0] o_idx,
    output logic             o_any
);

    logic [LOG_N-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = LOG_N'((32'(i_ptr) + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
//   Shares one L2 bank request pipeline among N_PORTS requesters with
//   round-robin arbitration, per-port outstanding-read credits and a
//   registered output stage. Credits return on read responses. `block`
//   stops new grants so the tile controller can wait for `idle`.
//   Ports:
//     clk, rstn       clock, asynchronous active-low reset
//     req_valid       [N]        per-port request valid
//     req_is_write    [N]        request is a posted write (no credit used)
//     req_data        [N*REQ_W]  payloads, port i at [i*REQ_W +: REQ_W]
//     req_ready       [N]        per-port accept (combinational)
//     out_valid/out_ready        registered request toward the bank
//     out_data/out_is_write/out_port  granted request
//     resp_valid/resp_port       read response, returns one credit
//     block                      gate all new grants this cycle
//     idle                       no registered request and no reads in flight
//     credit_err                 sticky: response with no matching read
// ---------------------------------------------------------------------------
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned N_PORTS     = L2_PORTS,
    parameter int unsigned REQ_W       = L2_REQ_W,
    parameter int unsigned LOG_MAX_OUT = LOG_N_MSHR,
    parameter int unsigned LOG_P       = clog2_min1(N_PORTS)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_PORTS-1:0]         req_valid,
    input  logic [N_PORTS-1:0]         req_is_write,
    input  logic [N_PORTS*REQ_W-1:0]   req_data,
    output logic [N_PORTS-1:0]         req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [REQ_W-1:0]           out_data,
    output logic                       out_is_write,
    output logic [LOG_P-1:0]           out_port,
    input  logic                       resp_valid,
    input  logic [LOG_P-1:0]           resp_port,
    input  logic                       block,
    output logic                       idle,
    output logic                       credit_err
);

    localparam int unsigned CNT_W = LOG_MAX_OUT + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {LOG_MAX_OUT{1'b0}}};

    // Registered state
    logic                 r_out_valid;
    logic [REQ_W-1:0]     r_out_data;
    logic                 r_out_is_write;
    logic [LOG_P-1:0]     r_out_port;
    logic [LOG_P-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]     r_cnt [N_PORTS];
    logic                 r_credit_err;

    // Combinational
    logic [N_PORTS-1:0]   w_elig;
    logic [N_PORTS-1:0]   w_arb_req;
    logic [N_PORTS-1:0]   w_grant;
    logic [LOG_P-1:0]     w_grant_idx;
    logic                 w_grant_any;
    logic                 w_load;
    logic [REQ_W-1:0]     w_sel_data;
    logic                 w_sel_is_write;
    logic [N_PORTS-1:0]   w_inc;
    logic [N_PORTS-1:0]   w_dec;
    logic                 w_resp_in_range;
    logic                 w_all_zero;

    // A full-width port id cannot be out of range; only compare when the
    // id space is larger than the port count.
    generate
        if (N_PORTS == (1 << LOG_P)) begin : g_resp_full
            assign w_resp_in_range = 1'b1;
        end else begin : g_resp_cmp
            assign w_resp_in_range = (32'(resp_port) < N_PORTS);
        end
    endgenerate

    assign w_load = ~r_out_valid | out_ready;

    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_elig[i] = req_valid[i]
                      & (req_is_write[i] | (r_cnt[i] < MAX_CNT))
                      & ~block;
        end
    end

    // rstn gating keeps req_ready low while reset is held, even though the
    // output stage already looks empty.
    assign w_arb_req = w_elig & {N_PORTS{w_load & rstn}};

    rr_arbiter #(
        .N     (N_PORTS),
        .LOG_N (LOG_P)
    ) u_rr (
        .i_req   (w_arb_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    assign req_ready = w_grant;

    // One-hot grant makes an OR-reduction mux sufficient.
    always_comb begin
        w_sel_data     = '0;
        w_sel_is_write = 1'b0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (w_grant[i]) begin
                w_sel_data     = w_sel_data | req_data[i*REQ_W +: REQ_W];
                w_sel_is_write = w_sel_is_write | req_is_write[i];
            end
        end
    end

    always_comb begin
        w_inc      = '0;
        w_dec      = '0;
        w_all_zero = 1'b1;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_inc[i] = w_grant[i] & ~req_is_write[i];
            w_dec[i] = resp_valid & w_resp_in_range & (resp_port == LOG_P'(i));
            if (r_cnt[i] != '0) begin
                w_all_zero = 1'b0;
            end
        end
    end

    // Output register stage; holds while the bank stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_is_write <= 1'b0;
            r_out_port     <= '0;
            r_rr_ptr       <= LOG_P'(N_PORTS - 1);
        end else if (w_grant_any) begin
            r_out_valid    <= 1'b1;
            r_out_data     <= w_sel_data;
            r_out_is_write <= w_sel_is_write;
            r_out_port     <= w_grant_idx;
            r_rr_ptr       <= w_grant_idx;
        end else if (w_load) begin
            r_out_valid    <= 1'b0;
        end
    end

    // Credit counters: a grant and a response on the same port cancel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                r_cnt[i] <= '0;
            end
            r_credit_err <= 1'b0;
        end else begin
            if (resp_valid && !w_resp_in_range) begin
                r_credit_err <= 1'b1;
            end
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    if (r_cnt[i] == '0) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_is_write = r_out_is_write;
    assign out_port     = r_out_port;
    assign idle         = ~r_out_valid & w_all_zero;
    assign credit_err   = r_credit_err;

endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;

    localparam int NP = 4;
    localparam int W  = 64;
    localparam int MAXO = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NP-1:0]   req_valid, req_is_write, req_ready;
    logic [NP*W-1:0] req_data;
    logic            out_valid, out_ready, out_is_write;
    logic [W-1:0]    out_data;
    logic [1:0]      out_port, resp_port;
    logic            resp_valid, block, idle, credit_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_ov, m_wr, m_err;
    logic [W-1:0] m_data;
    int          m_port, m_ptr;
    int          m_cnt [NP];

    l2_port_arbiter #(
        .N_PORTS     (NP),
        .REQ_W       (W),
        .LOG_MAX_OUT (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_is_write (req_is_write),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_is_write (out_is_write),
        .out_port     (out_port),
        .resp_valid   (resp_valid),
        .resp_port    (resp_port),
        .block        (block),
        .idle         (idle),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ov = 0; m_wr = 0; m_err = 0; m_data = '0; m_port = 0; m_ptr = NP - 1;
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    endfunction

    // Winner is the first eligible port after the last served one.
    function automatic int model_grant();
        int p;
        if (!rstn || block) return -1;
        if (m_ov && !out_ready) return -1;
        for (int k = 1; k <= NP; k++) begin
            p = (m_ptr + k) % NP;
            if (req_valid[p] && (req_is_write[p] || m_cnt[p] < MAXO)) return p;
        end
        return -1;
    endfunction

    function automatic void model_update(input int g);
        bit inc, dec;
        if (!rstn) begin
            model_reset();
            return;
        end
        for (int p = 0; p < NP; p++) begin
            inc = (g == p) && !req_is_write[p];
            dec = resp_valid && (int'(resp_port) == p);
            if (inc && !dec) m_cnt[p]++;
            else if (dec && !inc) begin
                if (m_cnt[p] == 0) m_err = 1;
                else m_cnt[p]--;
            end
        end
        if (g >= 0) begin
            m_ov = 1; m_data = req_data[g*W +: W]; m_wr = req_is_write[g];
            m_port = g; m_ptr = g;
        end else if (!m_ov || out_ready) begin
            m_ov = 0;
        end
    endfunction

    function automatic bit model_idle();
        bit z = !m_ov;
        for (int p = 0; p < NP; p++) if (m_cnt[p] != 0) z = 0;
        return z;
    endfunction

    task automatic check_all(input int g);
        logic [NP-1:0] er;
        er = (g >= 0) ? NP'(1 << g) : '0;
        chk("req_ready", W'(req_ready), W'(er));
        chk("out_valid", W'(out_valid), W'(m_ov));
        chk("out_data", out_data, m_data);
        chk("out_port", W'(out_port), W'(m_port));
        chk("out_is_write", W'(out_is_write), W'(m_wr));
        chk("idle", W'(idle), W'(model_idle()));
        chk("credit_err", W'(credit_err), W'(m_err));
    endtask

    // Inputs are stable from posedge+1; compare at negedge, then advance model.
    task automatic cycle();
        int g;
        @(negedge clk);
        g = model_grant();
        check_all(g);
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    task automatic set_in(input logic [NP-1:0] v, input logic [NP-1:0] wr,
                          input logic rv, input int rp);
        req_valid = v; req_is_write = wr; resp_valid = rv; resp_port = 2'(rp);
    endtask

    task automatic set_data(input int p, input logic [W-1:0] v);
        req_data[p*W +: W] = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 0; out_ready = 1; block = 0;
        set_in('0, '0, 0, 0);
        req_data = '0;
        model_reset();
        #1;
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_idle", W'(idle), 1);
        chk("rst_req_ready", W'(req_ready), 0);
        chk("rst_credit_err", W'(credit_err), 0);
        chk("rst_out_port", W'(out_port), 0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1;

        // Round-robin order with all four ports reading
        for (int p = 0; p < NP; p++) set_data(p, W'(64'h1000 + p));
        set_in(4'hF, 4'h0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_order", W'(out_port), W'(k % NP));
            chk("rr_valid", W'(out_valid), 1);
        end
        set_in('0, '0, 0, 0);
        cycle();
        for (int p = 0; p < NP; p++) begin
            for (int r = 0; r < 2; r++) begin
                set_in('0, '0, 1, p);
                cycle();
            end
        end
        set_in('0, '0, 0, 0);
        cycle();
        chk("rr_drained_idle", W'(idle), 1);

        // Port 2 credit exhaustion; writes still pass
        set_data(2, 64'h2222);
        set_in(4'b0100, 4'b0000, 0, 0);
        for (int k = 0; k < MAXO; k++) cycle();
        #1 chk("cred_stall", W'(req_ready[2]), 0);
        set_in(4'b0100, 4'b0100, 0, 0);
        #1 chk("cred_write_pass", W'(req_ready[2]), 1);
        cycle();
        chk("cred_write_out", W'(out_is_write), 1);
        set_in(4'b0100, 4'b0000, 1, 2);
        #1 chk("cred_resp_cycle", W'(req_ready[2]), 0);
        cycle();
        set_in(4'b0100, 4'b0000, 0, 0);
        #1 chk("cred_after_resp", W'(req_ready[2]), 1);
        cycle();
        set_in('0, '0, 1, 2);
        for (int k = 0; k < MAXO; k++) cycle();
        set_in('0, '0, 0, 0);
        cycle();
        chk("cred_drained_idle", W'(idle), 1);

        // Bank back-pressure holds the output stage
        set_data(0, 64'hABCD);
        set_in(4'b0001, '0, 0, 0);
        cycle();
        out_ready = 0;
        set_data(0, 64'h1111);
        set_in(4'hF, '0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_data", out_data, 64'hABCD);
            chk("stall_ready", W'(req_ready), 0);
        end
        out_ready = 1;
        #1 chk("stall_release_grant", W'(req_ready), W'(4'b0010));
        cycle();
        set_in('0, '0, 0, 0);
        cycle();
        set_in('0, '0, 1, 0); cycle();
        set_in('0, '0, 1, 1); cycle();
        set_in('0, '0, 0, 0); cycle();

        // Simultaneous grant and response on port 1 at cnt=3
        set_in(4'b0010, '0, 0, 0);
        for (int k = 0; k < 3; k++) cycle();
        set_in(4'b0010, '0, 1, 1);
        cycle();
        set_in('0, '0, 1, 1);
        cycle();
        cycle();
        set_in('0, '0, 0, 0);
        #1 chk("same_cycle_not_idle", W'(idle), 0);
        set_in('0, '0, 1, 1);
        cycle();
        set_in('0, '0, 0, 0);
        #1 chk("same_cycle_idle", W'(idle), 1);
        // Response with nothing outstanding
        set_in('0, '0, 1, 0);
        cycle();
        set_in('0, '0, 0, 0);
        #1 chk("credit_err_set", W'(credit_err), 1);
        cycle(); cycle();
        chk("credit_err_sticky", W'(credit_err), 1);

        // block gates grants; registered request still drains
        set_in(4'b0011, '0, 0, 0);
        cycle(); cycle();
        block = 1;
        set_in(4'hF, '0, 0, 0);
        #1 chk("block_no_grant", W'(req_ready), 0);
        chk("block_keeps_out", W'(out_valid), 1);
        cycle();
        chk("block_drained", W'(out_valid), 0);
        set_in(4'hF, '0, 1, 0); cycle();
        set_in(4'hF, '0, 1, 1); cycle();
        set_in(4'hF, '0, 0, 0);
        #1 chk("block_idle", W'(idle), 1);
        block = 0;
        #1 chk("block_resume", W'(req_ready), W'(4'b0100));
        cycle();
        chk("block_resume_port", W'(out_port), 2);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            for (int p = 0; p < NP; p++) set_data(p, {$urandom, $urandom});
            set_in(NP'($urandom), NP'($urandom), ($urandom_range(0, 2) == 0),
                   int'($urandom_range(0, NP - 1)));
            block     = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Drain, then build cnt[1]=5 with a request in the output stage
        block = 0; out_ready = 1;
        set_in('0, '0, 0, 0);
        cycle();
        for (int p = 0; p < NP; p++) begin
            while (m_cnt[p] > 0) begin
                set_in('0, '0, 1, p);
                cycle();
            end
        end
        set_data(1, 64'h5151);
        set_in(4'b0010, '0, 0, 0);
        for (int k = 0; k < 5; k++) cycle();
        chk("pre_rst_valid", W'(out_valid), 1);
        #2 rstn = 0;
        #1;
        chk("async_rst_out_valid", W'(out_valid), 0);
        chk("async_rst_idle", W'(idle), 1);
        chk("async_rst_credit_err", W'(credit_err), 0);
        chk("async_rst_ready", W'(req_ready), 0);
        model_reset();
        cycle();
        rstn = 1;
        for (int k = 0; k < 4; k++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
